// File: rtl/rd_req_arbiter_if.sv
// DDR read-command channel between rd_req_arbiter (master) and the DDR read controller (slave).
// Carries the shared command, its handshake, and the read-data/read-done strobes from the controller.
interface rd_req_arbiter_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16
);
    // Handshake: ddr_rreq is valid, ddr_rrdy is ready; the command transfers on the cycle both are
    // high, and ddr_raddr/ddr_rd_len hold stable while ddr_rreq is high. ddr_rdone pulses once per burst.
    logic                  ddr_rreq;
    logic [ADDR_WIDTH-1:0] ddr_raddr;
    logic [LEN_WIDTH-1:0]  ddr_rd_len;
    logic                  ddr_rrdy;
    logic                  ddr_rdone;
    logic                  ddr_rdata_en;

    modport master (
        output ddr_rreq, ddr_raddr, ddr_rd_len,
        input  ddr_rrdy, ddr_rdone, ddr_rdata_en
    );

    modport slave (
        input  ddr_rreq, ddr_raddr, ddr_rd_len,
        output ddr_rrdy, ddr_rdone, ddr_rdata_en
    );
endinterface

// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter sharing the DDR read-command port among three rd_cell fetchers.
// Optional watchdog: define RD_ARB_WDOG_EN to add a CMD/DATA timeout and the sticky wdog_err output.
module rd_req_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16
`ifdef RD_ARB_WDOG_EN
    ,
    parameter int                    WDOG_WIDTH = 16,
    parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = 16'hFFFF
`endif
) (
    input  logic                  ddr_clk,
    input  logic                  ddr_rstn,
    input  logic                  init_done,
    input  logic                  ddr_rreq1,
    input  logic                  ddr_rreq2,
    input  logic                  ddr_rreq3,
    input  logic [ADDR_WIDTH-1:0] ddr_raddr1,
    input  logic [ADDR_WIDTH-1:0] ddr_raddr2,
    input  logic [ADDR_WIDTH-1:0] ddr_raddr3,
    input  logic [LEN_WIDTH-1:0]  ddr_rd_len1,
    input  logic [LEN_WIDTH-1:0]  ddr_rd_len2,
    input  logic [LEN_WIDTH-1:0]  ddr_rd_len3,
    rd_req_arbiter_if.master      ddr,
    output logic                  ddr_rdata_en1,
    output logic                  ddr_rdata_en2,
    output logic                  ddr_rdata_en3,
    output logic                  rd_opera_en_1,
    output logic                  rd_opera_en_2,
    output logic                  rd_opera_en_3,
    output logic                  ddr_rdone1,
    output logic                  ddr_rdone2,
    output logic                  ddr_rdone3,
    output logic                  arb_busy,
    output logic [1:0]            state_dbg
`ifdef RD_ARB_WDOG_EN
    ,
    output logic                  wdog_err
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rreq_q, rreq_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            gnt_q, gnt_d;
    logic                  busy_q, busy_d;
    logic [1:0]            ptr_q, ptr_d;

    logic [2:0] req_vec;
    logic [2:0] cand;
    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] nxt_ptr;
    logic       rel_evt;
    logic       wdog_to;

    assign req_vec = {ddr_rreq3, ddr_rreq2, ddr_rreq1};

    // Scan from the farthest offset back to the pointer so the nearest requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (req_vec[cand[1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        nxt_ptr = 2'd0;
        if (gnt_q[0]) nxt_ptr = 2'd1;
        else if (gnt_q[1]) nxt_ptr = 2'd2;
    end

    // A burst ends on the controller's done (DATA only) or on a watchdog timeout.
    assign rel_evt = ((state_q == ST_DATA) && ddr.ddr_rdone) || wdog_to;

    always_comb begin
        state_d = state_q;
        rreq_d  = rreq_q;
        raddr_d = raddr_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        if (rel_evt) begin
            state_d = ST_RELEASE;
            rreq_d  = 1'b0;
            gnt_d   = 3'b000;
            busy_d  = 1'b0;
            ptr_d   = nxt_ptr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init_done && win_vld) begin
                        state_d = ST_CMD;
                        rreq_d  = 1'b1;
                        busy_d  = 1'b1;
                        gnt_d   = 3'b001 << win_idx;
                        case (win_idx)
                            2'd0:    begin raddr_d = ddr_raddr1; len_d = ddr_rd_len1; end
                            2'd1:    begin raddr_d = ddr_raddr2; len_d = ddr_rd_len2; end
                            default: begin raddr_d = ddr_raddr3; len_d = ddr_rd_len3; end
                        endcase
                    end
                end
                ST_CMD: begin
                    if (ddr.ddr_rrdy) begin
                        rreq_d  = 1'b0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA:    state_d = ST_DATA;
                ST_RELEASE: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

`ifdef RD_ARB_WDOG_EN
    logic [WDOG_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;

    assign wdog_to = ((state_q == ST_CMD) || (state_q == ST_DATA)) &&
                     (wcnt_q == WDOG_LIMIT - WDOG_WIDTH'(1));

    always_comb begin
        werr_d = werr_q | wdog_to;
        wcnt_d = wcnt_q;
        if (state_d != state_q) wcnt_d = '0;
        else if ((state_q == ST_CMD) || (state_q == ST_DATA)) wcnt_d = wcnt_q + WDOG_WIDTH'(1);
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            wcnt_q <= '0;
            werr_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            werr_q <= werr_d;
        end
    end

    assign wdog_err = werr_q;
`else
    assign wdog_to = 1'b0;
`endif

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state_q <= ST_IDLE;
            rreq_q  <= 1'b0;
            raddr_q <= '0;
            len_q   <= '0;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rreq_q  <= rreq_d;
            raddr_q <= raddr_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ddr.ddr_rreq   = rreq_q;
    assign ddr.ddr_raddr  = raddr_q;
    assign ddr.ddr_rd_len = len_q;
    assign rd_opera_en_1  = gnt_q[0];
    assign rd_opera_en_2  = gnt_q[1];
    assign rd_opera_en_3  = gnt_q[2];
    assign arb_busy       = busy_q;
    assign state_dbg      = state_q;

    // Data strobes only reach a cell while its burst is in the data phase.
    assign ddr_rdata_en1 = ddr.ddr_rdata_en & gnt_q[0] & (state_q == ST_DATA);
    assign ddr_rdata_en2 = ddr.ddr_rdata_en & gnt_q[1] & (state_q == ST_DATA);
    assign ddr_rdata_en3 = ddr.ddr_rdata_en & gnt_q[2] & (state_q == ST_DATA);
    assign ddr_rdone1    = rel_evt & gnt_q[0];
    assign ddr_rdone2    = rel_evt & gnt_q[1];
    assign ddr_rdone3    = rel_evt & gnt_q[2];
endmodule

// File: doc/rd_req_arbiter.md
Name: rd_req_arbiter

Overview:
Round-robin arbiter that shares the single DDR read-command port among the three rd_cell line fetchers of the read buffer: left half, right half and middle window. It selects one pending request, drives the shared command and the rd_opera_en select lines, and steers returned read-data strobes to the granted cell. It releases the port on the controller's read-done. It sits between rd_buf's rd_cell instances and the DDR read controller, in the ddr_clk domain.

Parameters:
ADDR_WIDTH, 27, width of DDR read address
LEN_WIDTH, 16, width of burst length field
WDOG_WIDTH, 16, width of watchdog counter (used only with optional feature)
WDOG_LIMIT, 16'hFFFF, watchdog timeout in ddr_clk cycles (used only with optional feature)

Ports:
ddr_clk  in  1  sole clock
ddr_rstn  in  1  asynchronous active-low reset
init_done  in  1  DDR calibration complete; no grants while low
ddr_rreq1/2/3  in  1 each  level request from rd_cell1/2/3; held until that cell's rdone
ddr_raddr1/2/3  in  ADDR_WIDTH each  per-cell read address
ddr_rd_len1/2/3  in  LEN_WIDTH each  per-cell burst length
ddr_rreq  out  1  shared read request to DDR controller
ddr_raddr  out  ADDR_WIDTH  shared read address (registered at grant)
ddr_rd_len  out  LEN_WIDTH  shared burst length (registered at grant)
ddr_rrdy  in  1  controller accepts request this cycle
ddr_rdone  in  1  one-cycle pulse at end of granted burst
ddr_rdata_en  in  1  controller read-data valid
ddr_rdata_en1/2/3  out  1 each  steered data-valid to the granted cell
rd_opera_en_1/2/3  out  1 each  one-hot grant indicator
ddr_rdone1/2/3  out  1 each  rdone steered to the granted cell
arb_busy  out  1  high from grant to release

Behaviour:
- Reset: all outputs 0. Address and length 0. FSM in IDLE. Round-robin pointer = cell1 highest priority.
- FSM states: IDLE, CMD, DATA, RELEASE.
- IDLE -> CMD: when init_done=1 and any ddr_rreqN=1. Winner is the first requester at or after the pointer, in circular order 1->2->3->1.
  - On that edge: latch raddr/rd_len of the winner; set rd_opera_en_N one-hot; assert ddr_rreq and arb_busy.
  - Request-to-ddr_rreq latency: 1 cycle.
- CMD: hold ddr_rreq, address and length stable until ddr_rrdy=1, then drop ddr_rreq and go to DATA.
  - ddr_rrdy in the first CMD cycle is accepted.
- DATA:
  - ddr_rdata_enN = ddr_rdata_en & rd_opera_en_N. Combinational, zero latency; other two ddr_rdata_en outputs stay 0.
  - On ddr_rdone: pulse ddr_rdone_N for one cycle (combinational from ddr_rdone gated by grant), go to RELEASE.
- RELEASE: one cycle; clear rd_opera_en_*, clear arb_busy, advance pointer to the cell after the winner, return to IDLE.
  - This bubble lets the cell drop its request before re-arbitration.
  - Minimum spacing between grants: 3 cycles.
- Simultaneous requests: the pointer decides; each requester is served at most once per three grants while all are pending.
- ddr_rdone, ddr_rrdy or ddr_rdata_en outside their expected states are ignored.
- Requester dropping its request after grant does not abort the transaction; it completes normally.
- init_done falling: no new grants; an in-flight transaction completes.
- Asynchronous reset mid-transaction: all outputs to 0 immediately; pointer to cell1.
- Address/length muxing is registered; rd_opera_en_* are registered state bits, never glitching.

Optional Feature:
RD_ARB_WDOG_EN
- Defined: a WDOG_WIDTH counter clears on every state change and increments in CMD and DATA.
  - Reaching WDOG_LIMIT forces RELEASE, pulses the granted ddr_rdone_N, and advances the pointer, so a hung controller cannot starve the other cells.
  - Adds output wdog_err (1 bit), a sticky flag set on timeout and cleared only by reset.
- Undefined: no counter and no wdog_err port; CMD/DATA wait indefinitely.

Test Plan:
- Reset then init_done=1, ddr_rreq1=1, raddr1=0x100, len1=16 -> next cycle ddr_rreq=1, ddr_raddr=0x100, ddr_rd_len=16, rd_opera_en_1=1; ddr_rrdy at cycle 3 drops ddr_rreq.
- All three requests held continuously, each burst done -> grant order 1,2,3,1,2,3; exactly one rd_opera_en_* high at any time; 3-cycle gaps between grants.
- Cell2 granted, ddr_rdata_en pulsed 8 times -> ddr_rdata_en2 pulses 8 times; ddr_rdata_en1/3 stay 0; ddr_rdone2 pulses once on ddr_rdone.
- Requests pending with init_done=0 -> ddr_rreq stays 0; init_done rises -> grant next cycle to cell1.
- ddr_rstn asserted during DATA of cell3 -> all outputs 0 asynchronously; after release with requests 2 and 3 pending -> cell2 granted first (pointer reset).
- With RD_ARB_WDOG_EN and WDOG_LIMIT=32, no ddr_rdone after grant -> RELEASE after 32 cycles in DATA, wdog_err=1 sticky, next pending cell granted.
